// File: rtl/alu_operand_stage.sv
// Decode-stage ALU operand resolution with EX/MEM and MEM/WB forwarding, registered into ID/EX.
// Per-operand shadows keep a forwarded value alive when its producer retires during a stall.
module alu_operand_stage #(
  parameter int          XLEN    = 32,
  parameter int          RA_W    = 5,
  parameter int unsigned B_CONST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [RA_W-1:0] rs1_addr,
  input  logic [RA_W-1:0] rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      a_sel,
  input  logic [1:0]      b_sel,
  input  logic            exmem_we,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_res,
  input  logic            memwb_we,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_res,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [XLEN-1:0] store_data,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  localparam logic [XLEN-1:0] B_CONST_EXT = XLEN'(B_CONST);

  localparam logic [1:0] SRC_RF     = 2'd0;
  localparam logic [1:0] SRC_MEMWB  = 2'd1;
  localparam logic [1:0] SRC_EXMEM  = 2'd2;
  localparam logic [1:0] SRC_SHADOW = 2'd3;

  logic [1:0]      live1_src, live2_src;
  logic [XLEN-1:0] live1_val, live2_val;
  logic [1:0]      res1_src, res2_src;
  logic [XLEN-1:0] res1_val, res2_val;
  logic [XLEN-1:0] op_a, op_b;

  logic            sh1_valid, sh2_valid;
  logic [XLEN-1:0] sh1_val, sh2_val;

  // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded.
  always_comb begin
    live1_src = SRC_RF;
    live1_val = rs1_data;
    if (exmem_we && exmem_rd == rs1_addr && rs1_addr != '0) begin
      live1_src = SRC_EXMEM;
      live1_val = exmem_res;
    end else if (memwb_we && memwb_rd == rs1_addr && rs1_addr != '0) begin
      live1_src = SRC_MEMWB;
      live1_val = memwb_res;
    end

    live2_src = SRC_RF;
    live2_val = rs2_data;
    if (exmem_we && exmem_rd == rs2_addr && rs2_addr != '0) begin
      live2_src = SRC_EXMEM;
      live2_val = exmem_res;
    end else if (memwb_we && memwb_rd == rs2_addr && rs2_addr != '0) begin
      live2_src = SRC_MEMWB;
      live2_val = memwb_res;
    end
  end

  // A valid shadow overrides the value; source reads 3 only once the live forward is gone.
  always_comb begin
    res1_val = sh1_valid ? sh1_val : live1_val;
    res1_src = (sh1_valid && live1_src == SRC_RF) ? SRC_SHADOW : live1_src;
    res2_val = sh2_valid ? sh2_val : live2_val;
    res2_src = (sh2_valid && live2_src == SRC_RF) ? SRC_SHADOW : live2_src;
  end

  always_comb begin
    case (a_sel)
      2'd1:    op_a = pc;
      2'd2:    op_a = '0;
      default: op_a = res1_val;
    endcase
    case (b_sel)
      2'd0:    op_b = res2_val;
      2'd2:    op_b = B_CONST_EXT;
      default: op_b = imm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      store_data <= '0;
      fwd_a      <= '0;
      fwd_b      <= '0;
      sh1_valid  <= 1'b0;
      sh1_val    <= '0;
      sh2_valid  <= 1'b0;
      sh2_val    <= '0;
    end else begin
      if (flush) begin
        out_valid  <= 1'b0;
        alu_in1    <= '0;
        alu_in2    <= '0;
        store_data <= '0;
        fwd_a      <= '0;
        fwd_b      <= '0;
      end else if (!stall) begin
        out_valid  <= in_valid;
        alu_in1    <= op_a;
        alu_in2    <= op_b;
        store_data <= res2_val;
        fwd_a      <= res1_src;
        fwd_b      <= res2_src;
      end

      // Capture only the first forwarded value seen within a stall window.
      if (flush || !stall) begin
        sh1_valid <= 1'b0;
        sh2_valid <= 1'b0;
      end else begin
        if (!sh1_valid && live1_src != SRC_RF) begin
          sh1_valid <= 1'b1;
          sh1_val   <= live1_val;
        end
        if (!sh2_valid && live2_src != SRC_RF) begin
          sh2_valid <= 1'b1;
          sh2_val   <= live2_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: reference model feeds an expected queue, plus directed
// checks against hand-computed constants for the key scenarios.
module tb_alu_operand_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] s;
    logic [1:0]      fa;
    logic [1:0]      fb;
  } exp_t;

  localparam int EW = $bits(exp_t);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, stall, flush, in_valid;
  logic [RA_W-1:0] rs1_addr, rs2_addr, exmem_rd, memwb_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, pc, exmem_res, memwb_res;
  logic [1:0]      a_sel, b_sel;
  logic            exmem_we, memwb_we;
  logic            out_valid;
  logic [XLEN-1:0] alu_in1, alu_in2, store_data;
  logic [1:0]      fwd_a, fwd_b;

  alu_operand_stage #(.XLEN(XLEN), .RA_W(RA_W), .B_CONST(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .a_sel(a_sel), .b_sel(b_sel),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_res(memwb_res),
    .out_valid(out_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .store_data(store_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  exp_t            m_out = '0;
  logic            m_sh1_v = 1'b0, m_sh2_v = 1'b0;
  logic [XLEN-1:0] m_sh1_val = '0, m_sh2_val = '0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [XLEN+1:0] live(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf);
    if (exmem_we && exmem_rd == rs && rs != 0) return {2'd2, exmem_res};
    if (memwb_we && memwb_rd == rs && rs != 0) return {2'd1, memwb_res};
    return {2'd0, rf};
  endfunction

  // Computes the outputs the DUT should show after the coming edge and pushes them.
  task automatic model_step();
    logic [XLEN+1:0] l1, l2;
    logic [1:0]      s1, s2;
    logic [XLEN-1:0] v1, v2;
    exp_t            n;
    l1 = live(rs1_addr, rs1_data);
    l2 = live(rs2_addr, rs2_data);
    s1 = l1[XLEN+1:XLEN]; v1 = l1[XLEN-1:0];
    s2 = l2[XLEN+1:XLEN]; v2 = l2[XLEN-1:0];
    if (m_sh1_v) begin v1 = m_sh1_val; if (s1 == 2'd0) s1 = 2'd3; end
    if (m_sh2_v) begin v2 = m_sh2_val; if (s2 == 2'd0) s2 = 2'd3; end
    n = m_out;
    if (rst || flush) n = '0;
    else if (!stall) begin
      n.v  = in_valid;
      n.a  = (a_sel == 2'd1) ? pc : (a_sel == 2'd2) ? '0 : v1;
      n.b  = (b_sel == 2'd0) ? v2 : (b_sel == 2'd2) ? 32'd4 : imm;
      n.s  = v2;
      n.fa = s1;
      n.fb = s2;
    end
    if (rst || flush || !stall) begin
      m_sh1_v = 1'b0;
      m_sh2_v = 1'b0;
    end else begin
      if (!m_sh1_v && l1[XLEN+1:XLEN] != 2'd0) begin m_sh1_v = 1'b1; m_sh1_val = l1[XLEN-1:0]; end
      if (!m_sh2_v && l2[XLEN+1:XLEN] != 2'd0) begin m_sh2_v = 1'b1; m_sh2_val = l2[XLEN-1:0]; end
    end
    m_out = n;
    exp_q.push_back(EW'(n));
  endtask

  // driver: one clock per call; inputs already set, result checked #1 after the edge
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check("sb_valid", {31'd0, out_valid}, {31'd0, e.v});
      check("sb_in1", alu_in1, e.a);
      check("sb_in2", alu_in2, e.b);
      check("sb_store", store_data, e.s);
      check("sb_fwd_a", {30'd0, fwd_a}, {30'd0, e.fa});
      check("sb_fwd_b", {30'd0, fwd_b}, {30'd0, e.fb});
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 1;
    rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
    a_sel = 0; b_sel = 0;
    exmem_we = 0; exmem_rd = 0; exmem_res = 0;
    memwb_we = 0; memwb_rd = 0; memwb_res = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    // 1. reset then first operand
    cycle(); cycle();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in1", alu_in1, 32'd0);
    check("rst_in2", alu_in2, 32'd0);
    rst = 0;
    rs1_addr = 3; rs1_data = 32'h10; b_sel = 1; imm = 32'hFFFF_FFF0;
    cycle();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_in1", alu_in1, 32'h10);
    check("t1_in2", alu_in2, 32'hFFFF_FFF0);
    check("t1_fwd_a", {30'd0, fwd_a}, 32'd0);

    // 2. EX/MEM beats MEM/WB on the same rd
    rs1_addr = 5; rs1_data = 32'h1;
    exmem_we = 1; exmem_rd = 5; exmem_res = 32'hAA;
    memwb_we = 1; memwb_rd = 5; memwb_res = 32'hBB;
    cycle();
    check("t2_in1_ex", alu_in1, 32'hAA);
    check("t2_fwd_a_ex", {30'd0, fwd_a}, 32'd2);
    exmem_we = 0;
    cycle();
    check("t2_in1_wb", alu_in1, 32'hBB);
    check("t2_fwd_a_wb", {30'd0, fwd_a}, 32'd1);
    memwb_we = 0;

    // 3. x0 is never forwarded
    rs2_addr = 0; rs2_data = 0; b_sel = 0;
    exmem_we = 1; exmem_rd = 0; exmem_res = 32'h55;
    cycle();
    check("t3_store", store_data, 32'd0);
    check("t3_fwd_b", {30'd0, fwd_b}, 32'd0);

    // 4. stall while the producer retires; release must register the shadow
    rs1_addr = 7; rs1_data = 32'h0; a_sel = 0;
    exmem_we = 1; exmem_rd = 7; exmem_res = 32'h1234;
    stall = 1;
    cycle();
    exmem_we = 0; rs1_data = 32'hDEAD;
    cycle(); cycle();
    stall = 0;
    cycle();
    check("t4_in1", alu_in1, 32'h1234);
    check("t4_fwd_a", {30'd0, fwd_a}, 32'd3);
    cycle();
    check("t4_after_in1", alu_in1, 32'hDEAD);

    // 5. flush wins over stall and discards any shadow
    exmem_we = 1; exmem_rd = 7; exmem_res = 32'h99;
    stall = 1; flush = 1;
    cycle();
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    check("t5_in1", alu_in1, 32'd0);
    check("t5_in2", alu_in2, 32'd0);
    stall = 0; flush = 0; exmem_we = 0; rs1_data = 32'h77;
    cycle();
    check("t5_fresh_in1", alu_in1, 32'h77);
    check("t5_fresh_fwd_a", {30'd0, fwd_a}, 32'd0);

    // 6. constants, aliases and in_valid=0
    a_sel = 1; pc = 32'h8000_0004; b_sel = 2; imm = 32'h0000_0123;
    cycle();
    check("t6_pc", alu_in1, 32'h8000_0004);
    check("t6_const", alu_in2, 32'd4);
    a_sel = 2; b_sel = 3;
    cycle();
    check("t6_zero", alu_in1, 32'd0);
    check("t6_alias_b", alu_in2, 32'h0000_0123);
    a_sel = 3; rs1_data = 32'h4242; in_valid = 0;
    cycle();
    check("t6_alias_a", alu_in1, 32'h4242);
    check("t6_invalid", {31'd0, out_valid}, 32'd0);

    // random mix against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      rs1_addr  = RA_W'($urandom_range(0, 3));
      rs2_addr  = RA_W'($urandom_range(0, 3));
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      imm       = $urandom;
      pc        = $urandom;
      a_sel     = 2'($urandom_range(0, 3));
      b_sel     = 2'($urandom_range(0, 3));
      exmem_we  = 1'($urandom_range(0, 1));
      exmem_rd  = RA_W'($urandom_range(0, 3));
      exmem_res = $urandom;
      memwb_we  = 1'($urandom_range(0, 1));
      memwb_rd  = RA_W'($urandom_range(0, 3));
      memwb_res = $urandom;
      cycle();
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised successor to the single-bit ALU operand-B mux.
- Resolves both ALU operands in decode and registers them into the ID/EX boundary.
- Operand sources: register, PC, immediate and constants, with EX/MEM and MEM/WB forwarding.
- Holds stable operands across pipeline stalls, including forwarded values whose producer retires during the stall.

Parameters:
- XLEN, 32, datapath width in bits.
- RA_W, 5, register-address width.
- B_CONST, 4, constant presented on operand B when b_sel=2 (link address offset).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the ID/EX register; from the hazard unit.
- flush  in  1  kill the ID/EX contents (bubble).
- in_valid  in  1  decode-stage instruction valid.
- rs1_addr  in  RA_W  source register 1 index.
- rs2_addr  in  RA_W  source register 2 index.
- rs1_data  in  XLEN  register-file read port 1.
- rs2_data  in  XLEN  register-file read port 2.
- imm  in  XLEN  sign-extended immediate.
- pc  in  XLEN  decode-stage PC.
- a_sel  in  2  operand A source: 0=rs1, 1=pc, 2=zero, 3=rs1.
- b_sel  in  2  operand B source: 0=rs2, 1=imm, 2=B_CONST, 3=imm.
- exmem_we  in  1  EX/MEM register-write enable.
- exmem_rd  in  RA_W  EX/MEM destination register.
- exmem_res  in  XLEN  EX/MEM result.
- memwb_we  in  1  MEM/WB register-write enable.
- memwb_rd  in  RA_W  MEM/WB destination register.
- memwb_res  in  XLEN  MEM/WB writeback value.
- out_valid  out  1  ID/EX valid.
- alu_in1  out  XLEN  registered operand A.
- alu_in2  out  XLEN  registered operand B.
- store_data  out  XLEN  registered forwarded rs2, used for stores regardless of b_sel.
- fwd_a  out  2  registered forward source for rs1: 0=regfile, 1=MEM/WB, 2=EX/MEM, 3=shadow.
- fwd_b  out  2  registered forward source for rs2, same encoding.

Behaviour:
- Reset: at a clk edge with rst=1, all outputs and both shadows clear to 0; rst takes priority over flush and stall.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Forward resolution, per source rs (combinational):
  - If exmem_we and exmem_rd==rs and rs!=0: use exmem_res.
  - Else if memwb_we and memwb_rd==rs and rs!=0: use memwb_res.
  - Else: use the register-file data.
  - EX/MEM beats MEM/WB. Register x0 always resolves to the regfile value and is never forwarded.
- Shadow capture, independent per operand (rs1 and rs2), each with a shadow_valid flag, shadow value and shadow source:
  - On any edge with stall=1, flush=0, shadow_valid=0 and a forwarding hit, the shadow takes the forwarded value and source, and shadow_valid is set.
  - While shadow_valid=1, the resolved value is the shadow value. The reported source is 3 if the live forward has gone, otherwise the live source.
  - shadow_valid clears on any edge with stall=0, on flush, and on rst.
- Register update:
  - flush=1 (wins over stall): out_valid<=0; alu_in1, alu_in2, store_data, fwd_a and fwd_b <=0.
  - stall=1, flush=0: all outputs hold their values.
  - Otherwise: out_valid<=in_valid, alu_in1<=mux(a_sel), alu_in2<=mux(b_sel), store_data<=resolved rs2, fwd_a and fwd_b <= sources.
- Width rules:
  - All data is XLEN bits, with no arithmetic.
  - B_CONST is zero-extended to XLEN.
  - Selector codes 3 alias 0 (a_sel) and 1 (b_sel), so there are no X outputs.
- Boundaries:
  - Both forward stages hitting the same rd: EX/MEM is used.
  - A stall released in the same cycle the producer leaves EX/MEM: the shadow value is the one registered.
  - in_valid=0 still registers data, but out_valid=0.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> all outputs 0. Release rst; in_valid=1, a_sel=0, b_sel=1, rs1_data=0x10, imm=0xFFFFFFF0, no forwards -> next cycle alu_in1=0x10, alu_in2=0xFFFFFFF0, out_valid=1, fwd_a=0.
2. Priority: rs1_addr=5, exmem(we=1,rd=5,res=0xAA), memwb(we=1,rd=5,res=0xBB) -> alu_in1=0xAA, fwd_a=2. Remove exmem -> alu_in1=0xBB, fwd_a=1.
3. x0 guard: rs2_addr=0, exmem(we=1,rd=0,res=0x55), rs2_data=0 -> store_data=0, fwd_b=0.
4. Stall with retiring producer: rs1 fwd from exmem=0x1234. Assert stall for 3 cycles; after the first stalled edge exmem_we drops and rs1_data=0xDEAD. Release stall -> alu_in1=0x1234, fwd_a=3.
5. Flush vs stall: stall=1 and flush=1 together -> out_valid=0, alu_in1=0, alu_in2=0, shadows cleared. The next unstalled cycle registers fresh operands.
6. Constants and aliases: a_sel=1, pc=0x80000004, b_sel=2 -> alu_in1=0x80000004, alu_in2=4. a_sel=2 -> alu_in1=0. b_sel=3 -> alu_in2=imm.
